dm_ctrl: RTL and testbench
==========================

DM_CTRL -- requirements
Module: dm_ctrl

Interface
REQ-001 SHALL have parameter RD_WAIT, default 0, meaning extra wait cycles (0..3) before mem_rdata is sampled.
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req  in  1  CPU access request; sampled only in IDLE.
REQ-005 SHALL have port we  in  1  1=store, 0=load.
REQ-006 SHALL have port size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-007 SHALL have port sign_ext  in  1  loads: 1 sign-extend, 0 zero-extend.
REQ-008 SHALL have port addr  in  32  CPU byte address.
REQ-009 SHALL have port wdata  in  32  store data, right-aligned.
REQ-010 SHALL have port rdata  out  32  load result, right-aligned and extended.
REQ-011 SHALL have port done  out  1  one-cycle completion pulse.
REQ-012 SHALL have port busy  out  1  CPU stall; 1 whenever state != IDLE.
REQ-013 SHALL have port misalign  out  1  one-cycle fault pulse.
REQ-014 SHALL have ports mem_addr out 32, mem_wdata out 32, mem_we out 1, mem_rdata in 32; these drive the word-only data memory (word index = mem_addr[11:2], combinational read, write on rising edge).

Function
REQ-015 SHALL use states IDLE, RD, WR, DN, all outputs registered.
REQ-016 SHALL flag as misaligned: size 11; half with addr[0]=1; word with addr[1:0]!=0.
REQ-017 In IDLE with req=1 and misaligned: no memory access, misalign=1 next cycle, done stays 0, remain IDLE.
REQ-018 In IDLE with req=1 and aligned: capture addr, wdata, size, we, sign_ext; set mem_addr={addr[31:2],2'b00}.
REQ-019 Word store SHALL go IDLE->WR: mem_we=1 for exactly one cycle with mem_wdata=wdata, done=1 in that cycle, then IDLE.
REQ-020 Load or sub-word store SHALL go IDLE->RD, hold RD for RD_WAIT+1 cycles, and sample mem_rdata on the last RD cycle.
REQ-021 Load SHALL go RD->DN: rdata valid and done=1 in DN, then IDLE; rdata holds until the next load completes.
REQ-022 Load extraction SHALL be little-endian: byte lane k = addr[1:0], bits [8k+7:8k]; half lane = addr[1], bits [16h+15:16h]; result extended per sign_ext.
REQ-023 Sub-word store SHALL go RD->WR and write the read word with only the addressed byte or half replaced by wdata[7:0] or wdata[15:0]; done=1 in WR.
REQ-024 Latency with RD_WAIT=0, counted from the accept edge: sw done at +1, load and sb/sh done at +2; add RD_WAIT for RD paths.
REQ-025 req, addr and wdata SHALL be ignored while busy=1; back-to-back requests are accepted in the cycle after done.
REQ-026 mem_we SHALL be 0 in every state except WR.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, wait counter 0, and rdata, done, busy, misalign, mem_we, mem_addr and mem_wdata all 0.
REQ-028 Reset in RD or WR SHALL abort the operation; mem_we drops asynchronously and no partial write occurs after release.

Configuration
REQ-029 Macro DM_CTRL_BYTE_EN defined: byte and half accesses are supported per REQ-020..023.
REQ-030 Macro DM_CTRL_BYTE_EN undefined: size 00 and 01 are treated as misaligned per REQ-017; RD, WR and DN paths are for word access only, and no RMW logic is built.

Verification
REQ-031 sw addr=0x10 wdata=0xDEADBEEF -> mem_we=1 one cycle, mem_addr=0x10, done at +1; then lw 0x10 -> rdata=0xDEADBEEF, done at +2.
REQ-032 Memory word 0x11223344 at 0x20; sb addr=0x22 wdata=0xAA -> memory becomes 0x11AA3344, done at +2.
REQ-033 Memory word 0x80F0017F at 0x30; lb 0x33 sign_ext=1 -> 0xFFFFFF80; lhu 0x32 -> 0x000080F0; lb 0x30 -> 0x0000007F.
REQ-034 lw addr=0x41 -> misalign pulse, no mem_we, done=0, busy=0; size=11 -> same response.
REQ-035 RD_WAIT=2, sh 0x52 wdata=0x1234 with rst_n pulsed low during RD -> no write occurs, all outputs 0, next lw completes normally.
REQ-036 req held high for 4 cycles with sw -> writes at +1 and +3, busy pattern 1,0,1,0.

Source files
------------

// File: rtl/dm_ctrl.sv
// Data-memory access controller: CPU byte/half/word loads and stores onto a word-only memory.
// Define DM_CTRL_BYTE_EN to enable byte/half accesses (read-modify-write for sub-word stores).
module dm_ctrl #(
    parameter int RD_WAIT = 0
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        busy,
    output logic        misalign,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        DN   = 2'b11
    } state_t;

    localparam logic [1:0] SZ_BYTE   = 2'b00;
    localparam logic [1:0] SZ_HALF   = 2'b01;
    localparam logic [1:0] SZ_WORD   = 2'b10;
    localparam logic [1:0] RD_WAIT_C = RD_WAIT[1:0];

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        logic r;
        case (sz)
`ifdef DM_CTRL_BYTE_EN
            SZ_BYTE: r = 1'b0;
            SZ_HALF: r = off[0];
`else
            SZ_BYTE, SZ_HALF: r = 1'b1;
`endif
            SZ_WORD: r = (off != 2'b00);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    // Little-endian lane select followed by sign or zero extension.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] sz,
                                                 input logic [1:0] off, input logic sx);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (sz)
            SZ_BYTE: r = {{24{sx & b[7]}}, b};
            SZ_HALF: r = {{16{sx & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

`ifdef DM_CTRL_BYTE_EN
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] sz,
                                                input logic [1:0] off, input logic [15:0] data);
        logic [31:0] r;
        r = word;
        case (sz)
            SZ_BYTE: begin
                case (off)
                    2'b00:   r[7:0]   = data[7:0];
                    2'b01:   r[15:8]  = data[7:0];
                    2'b10:   r[23:16] = data[7:0];
                    default: r[31:24] = data[7:0];
                endcase
            end
            SZ_HALF: begin
                if (off[1]) begin
                    r[31:16] = data;
                end else begin
                    r[15:0] = data;
                end
            end
            default: r = word;
        endcase
        return r;
    endfunction
`endif

    state_t      state_r, state_s;
    logic [1:0]  wait_cnt_r, wait_cnt_s;
    logic [1:0]  off_r, off_s;
    logic [1:0]  size_r, size_s;
    logic        we_r, we_s;
    logic        sign_ext_r, sign_ext_s;
    logic [31:0] rdata_r, rdata_s;
    logic        done_r, done_s;
    logic        busy_r, busy_s;
    logic        misalign_r, misalign_s;
    logic [31:0] mem_addr_r, mem_addr_s;
    logic [31:0] mem_wdata_r, mem_wdata_s;
    logic        mem_we_r, mem_we_s;
`ifdef DM_CTRL_BYTE_EN
    logic [15:0] wdata_r, wdata_s;
`endif

    // Next-state and next-output logic; every output is the registered copy of these values.
    always_comb begin
        state_s     = state_r;
        wait_cnt_s  = wait_cnt_r;
        off_s       = off_r;
        size_s      = size_r;
        we_s        = we_r;
        sign_ext_s  = sign_ext_r;
        rdata_s     = rdata_r;
        done_s      = 1'b0;
        misalign_s  = 1'b0;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        mem_we_s    = 1'b0;
`ifdef DM_CTRL_BYTE_EN
        wdata_s     = wdata_r;
`endif
        case (state_r)
            IDLE: begin
                if (req) begin
                    if (is_misaligned(size, addr[1:0])) begin
                        misalign_s = 1'b1;
                    end else begin
                        mem_addr_s = {addr[31:2], 2'b00};
                        off_s      = addr[1:0];
                        size_s     = size;
                        we_s       = we;
                        sign_ext_s = sign_ext;
                        wait_cnt_s = 2'b00;
`ifdef DM_CTRL_BYTE_EN
                        wdata_s    = wdata[15:0];
`endif
                        // Full-word stores need no read and complete directly.
                        if (we && (size == SZ_WORD)) begin
                            state_s     = WR;
                            mem_we_s    = 1'b1;
                            mem_wdata_s = wdata;
                            done_s      = 1'b1;
                        end else begin
                            state_s = RD;
                        end
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RD: begin
                if (wait_cnt_r == RD_WAIT_C) begin
                    wait_cnt_s = 2'b00;
                    if (we_r) begin
`ifdef DM_CTRL_BYTE_EN
                        state_s     = WR;
                        mem_we_s    = 1'b1;
                        mem_wdata_s = store_merge(mem_rdata, size_r, off_r, wdata_r);
                        done_s      = 1'b1;
`else
                        state_s     = IDLE;
`endif
                    end else begin
                        state_s = DN;
                        rdata_s = load_extract(mem_rdata, size_r, off_r, sign_ext_r);
                        done_s  = 1'b1;
                    end
                end else begin
                    wait_cnt_s = wait_cnt_r + 2'd1;
                end
            end
            WR:      state_s = IDLE;
            DN:      state_s = IDLE;
            default: state_s = IDLE;
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and output registers; reset clears everything, aborting any access in flight.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            wait_cnt_r  <= 2'b00;
            off_r       <= 2'b00;
            size_r      <= 2'b00;
            we_r        <= 1'b0;
            sign_ext_r  <= 1'b0;
            rdata_r     <= 32'h0000_0000;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            misalign_r  <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_wdata_r <= 32'h0000_0000;
            mem_we_r    <= 1'b0;
`ifdef DM_CTRL_BYTE_EN
            wdata_r     <= 16'h0000;
`endif
        end else begin
            state_r     <= state_s;
            wait_cnt_r  <= wait_cnt_s;
            off_r       <= off_s;
            size_r      <= size_s;
            we_r        <= we_s;
            sign_ext_r  <= sign_ext_s;
            rdata_r     <= rdata_s;
            done_r      <= done_s;
            busy_r      <= busy_s;
            misalign_r  <= misalign_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            mem_we_r    <= mem_we_s;
`ifdef DM_CTRL_BYTE_EN
            wdata_r     <= wdata_s;
`endif
        end
    end

    assign rdata     = rdata_r;
    assign done      = done_r;
    assign busy      = busy_r;
    assign misalign  = misalign_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_we    = mem_we_r;

endmodule

// File: tb/tb_dm_ctrl.sv
// Self-checking bench for dm_ctrl: directed scenarios plus randomized accesses against a
// behavioural memory/access model; follows DM_CTRL_BYTE_EN when it is defined.
module tb_dm_ctrl;

    localparam int RDW = 2;

    logic        clock;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        busy;
    logic        misalign;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        pl_we;
    logic [9:0]  pl_idx;
    logic [31:0] pl_data;

    int n_checks;
    int n_fail;

    dm_ctrl #(.RD_WAIT(RDW)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .size      (size),
        .sign_ext  (sign_ext),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .done      (done),
        .busy      (busy),
        .misalign  (misalign),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Word-only data memory: combinational read, write on the rising edge.
    assign mem_rdata = mem[mem_addr[11:2]];
    always @(posedge clock) begin
        if (pl_we) begin
            mem[pl_idx] <= pl_data;
        end else if (mem_we) begin
            mem[mem_addr[11:2]] <= mem_wdata;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit ref_misaligned(input logic [1:0] sz, input logic [31:0] a);
        bit byte_en;
`ifdef DM_CTRL_BYTE_EN
        byte_en = 1'b1;
`else
        byte_en = 1'b0;
`endif
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd2) return (a % 4) != 0;
        if (!byte_en) return 1'b1;
        if (sz == 2'd1) return (a % 2) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] sz,
                                             input logic [31:0] a, input logic sx);
        logic [31:0] v;
        int k;
        k = int'(a % 4);
        if (sz == 2'd0) begin
            v = (word >> (8 * k)) & 32'h0000_00FF;
            if (sx && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (word >> (16 * (k / 2))) & 32'h0000_FFFF;
            if (sx && v >= 32'h0000_8000) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [1:0] sz,
                                              input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] mask;
        int k;
        k = int'(a % 4);
        if (sz == 2'd0) begin
            mask = 32'h0000_00FF << (8 * k);
            return (word & ~mask) | ((wd & 32'h0000_00FF) << (8 * k));
        end else if (sz == 2'd1) begin
            mask = 32'h0000_FFFF << (16 * (k / 2));
            return (word & ~mask) | ((wd & 32'h0000_FFFF) << (16 * (k / 2)));
        end
        return wd;
    endfunction

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clock);
        pl_we   = 1'b1;
        pl_idx  = 10'(idx);
        pl_data = val;
        @(negedge clock);
        pl_we   = 1'b0;
        ref_mem[idx] = val;
    endtask

    // One CPU access, checked cycle by cycle; with noise the CPU inputs churn while busy.
    task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd, input bit noise);
        logic [31:0] exp_word;
        logic [31:0] exp_rd;
        int idx;
        int lat;
        idx = int'(a[11:2]);
        @(negedge clock);
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
        @(posedge clock);
        #1;
        if (ref_misaligned(sz, a)) begin
            req = 1'b0;
            check_eq("mis_pulse", misalign, 1'b1);
            check_eq("mis_done", done, 1'b0);
            check_eq("mis_busy", busy, 1'b0);
            check_eq("mis_we", mem_we, 1'b0);
            @(posedge clock);
            #1;
            check_eq("mis_clear", misalign, 1'b0);
            check_eq("mis_mem", mem[idx], ref_mem[idx]);
            return;
        end
        lat      = (w && sz == 2'd2) ? 1 : 2 + RDW;
        exp_word = w ? ref_store(ref_mem[idx], sz, a, wd) : ref_mem[idx];
        exp_rd   = ref_load(ref_mem[idx], sz, a, sx);
        for (int c = 1; c <= lat; c++) begin
            if (noise) begin
                req = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
                size = 2'($urandom_range(0, 3)); sign_ext = 1'($urandom_range(0, 1));
                addr = $urandom; wdata = $urandom;
            end else begin
                req = 1'b0;
            end
            check_eq("acc_busy", busy, 1'b1);
            check_eq("acc_done", done, (c == lat) ? 1'b1 : 1'b0);
            check_eq("acc_mem_we", mem_we, (w && c == lat) ? 1'b1 : 1'b0);
            check_eq("acc_misalign", misalign, 1'b0);
            if (c == lat) begin
                check_eq("acc_mem_addr", mem_addr, {a[31:2], 2'b00});
                if (w) begin
                    check_eq("acc_mem_wdata", mem_wdata, exp_word);
                end else begin
                    check_eq("acc_rdata", rdata, exp_rd);
                end
            end else begin
                @(posedge clock);
                #1;
            end
        end
        @(posedge clock);
        #1;
        req = 1'b0;
        check_eq("end_busy", busy, 1'b0);
        check_eq("end_done", done, 1'b0);
        check_eq("end_mem_we", mem_we, 1'b0);
        if (w) begin
            ref_mem[idx] = exp_word;
            check_eq("end_mem_word", mem[idx], exp_word);
        end else begin
            check_eq("end_rdata_hold", rdata, exp_rd);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = 32'h0; wdata = 32'h0; pl_we = 1'b0; pl_idx = 10'd0; pl_data = 32'h0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        for (int i = 0; i < 64; i++) preload(i, $urandom);
        preload(8, 32'h1122_3344);
        preload(12, 32'h80F0_017F);
        #1;
        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_misalign", misalign, 1'b0);
        check_eq("rst_mem_we", mem_we, 1'b0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_mem_wdata", mem_wdata, 32'h0);
        @(negedge clock);
        rst_n = 1'b1;

        access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
        access(1'b1, 2'd0, 1'b0, 32'h22, 32'h0000_00AA, 1'b0);
`ifdef DM_CTRL_BYTE_EN
        check_eq("sb_word", mem[8], 32'h11AA_3344);
`else
        check_eq("sb_word", mem[8], 32'h1122_3344);
`endif
        access(1'b0, 2'd0, 1'b1, 32'h33, 32'h0, 1'b0);
        access(1'b0, 2'd1, 1'b0, 32'h32, 32'h0, 1'b0);
        access(1'b0, 2'd0, 1'b0, 32'h30, 32'h0, 1'b0);
        access(1'b0, 2'd2, 1'b0, 32'h41, 32'h0, 1'b0);
        access(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 1'b0);

        // req held for four cycles with a word store: accepted twice.
        @(negedge clock);
        req = 1'b1; we = 1'b1; size = 2'd2; sign_ext = 1'b0; addr = 32'h60; wdata = 32'hCAFE_F00D;
        for (int c = 0; c < 4; c++) begin
            @(posedge clock);
            #1;
            check_eq("b2b_busy", busy, (c % 2 == 0) ? 1'b1 : 1'b0);
            check_eq("b2b_mem_we", mem_we, (c % 2 == 0) ? 1'b1 : 1'b0);
            if (c == 3) req = 1'b0;
        end
        ref_mem[24] = 32'hCAFE_F00D;
        check_eq("b2b_word", mem[24], 32'hCAFE_F00D);

        // Reset asserted while the controller is in RD.
        @(negedge clock);
        req = 1'b1; sign_ext = 1'b0; wdata = 32'h0000_1234;
`ifdef DM_CTRL_BYTE_EN
        we = 1'b1; size = 2'd1; addr = 32'h52;
`else
        we = 1'b0; size = 2'd2; addr = 32'h50;
`endif
        @(posedge clock);
        #1;
        req = 1'b0;
        check_eq("rrd_busy", busy, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("rrd_rdata", rdata, 32'h0);
        check_eq("rrd_done", done, 1'b0);
        check_eq("rrd_busy0", busy, 1'b0);
        check_eq("rrd_misalign", misalign, 1'b0);
        check_eq("rrd_mem_we", mem_we, 1'b0);
        check_eq("rrd_mem_addr", mem_addr, 32'h0);
        check_eq("rrd_mem_wdata", mem_wdata, 32'h0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clock);
            #1;
            check_eq("rrd_idle_we", mem_we, 1'b0);
        end
        check_eq("rrd_no_write", mem[20], ref_mem[20]);
        access(1'b0, 2'd2, 1'b0, 32'h50, 32'h0, 1'b0);

        for (int i = 0; i < 250; i++) begin
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, 255)), $urandom, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
